stage_m2: RTL and testbench

STAGE_M2 -- requirements
Module: stage_m2

---
 rtl/riscv_defines.sv | 35 +++
 rtl/stage_m2_if.sv | 10 +
 rtl/stage_m2_load_extend.sv | 32 +++
 rtl/stage_m2.sv | 120 ++++++++++++
 tb/tb_stage_m2.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_defines.sv
// Shared pipeline types, result-source and load funct3 encodings for the M2 stage.
package riscv_defines;

  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memread;
    logic       memwrite;
  } control_signal_t;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {M2_RUN, M2_WAIT} m2_state_t;

  typedef struct packed {
    logic [4:0]  rd_m2;
    logic        regwrite_m2;
    logic [31:0] result_m2;
    logic        busy_m2;
  } hazard_req_t;

  typedef struct packed {
    logic stall_m2;
    logic flush_m2;
  } hazard_res_t;

endpackage

// File: rtl/stage_m2_if.sv
// Hazard unit link: M2 publishes its writeback/busy view, hazard unit returns stall/flush.
interface hazard_interface;
  import riscv_defines::*;

  hazard_req_t req;
  hazard_res_t res;

  modport requester (output req, input res);
  modport resolver  (input req, output res);
endinterface

// File: rtl/stage_m2_load_extend.sv
// Load alignment and sign/zero extension of a data-memory word.
module load_extend
  import riscv_defines::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] extended
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   extended = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  extended = {24'b0, byte_sel};
      F3_LH:   extended = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  extended = {16'b0, half_sel};
      default: extended = rdata;
    endcase
  end

endmodule

// File: rtl/stage_m2.sv
// Second memory stage: holds the M1->M2 register, waits on dmem_rvalid and
// extends load data for writeback, bubbling WB while a load is outstanding.
module stage_m2
  import riscv_defines::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  control_signal_t           control_signal_m1,
  input  logic [4:0]                rd_m1,
  input  logic [2:0]                funct3_m1,
  input  logic [31:0]               result_m1,
  input  logic [31:0]               dmem_rdata,
  input  logic                      dmem_rvalid,
  output control_signal_t           control_signal_m2,
  output logic [4:0]                rd_m2,
  output logic [31:0]               memresult_m2,
  output logic [31:0]               result_m2,
  hazard_interface.requester        hazard_bus
);

  // state   | meaning
  // M2_RUN  | register may advance; any load in it has its data
  // M2_WAIT | load in register, still waiting for dmem_rvalid
  m2_state_t state, state_next;

  control_signal_t ctrl_q;
  logic [4:0]      rd_q;
  logic [2:0]      funct3_q;
  logic [31:0]     result_q;
  logic [31:0]     hold_data;
  logic            hold_valid;

  logic            stall, flush, busy, advance;
  logic [31:0]     load_word, extended;
  hazard_req_t     req_d;

  assign stall   = hazard_bus.res.stall_m2;
  assign flush   = hazard_bus.res.flush_m2;
  assign busy    = ctrl_q.memread & ~dmem_rvalid & ~hold_valid;
  assign advance = ~stall & ~busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
      result_q <= '0;
    end else if (flush) begin
      ctrl_q <= '0;
    end else if (advance) begin
      ctrl_q   <= control_signal_m1;
      rd_q     <= rd_m1;
      funct3_q <= funct3_m1;
      result_q <= result_m1;
    end
  end

  // Data arriving while the pipe is stalled is parked until the register advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else begin
      if (advance)
        hold_valid <= 1'b0;
      else if (stall && dmem_rvalid && ctrl_q.memread)
        hold_valid <= 1'b1;
      if (dmem_rvalid && ctrl_q.memread)
        hold_data <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= M2_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    control_signal_m2 = ctrl_q;
    rd_m2             = rd_q;
    if (flush) begin
      state_next = M2_RUN;
    end else begin
      case (state)
        M2_RUN:  if (busy) state_next = M2_WAIT;
        M2_WAIT: if (dmem_rvalid) state_next = M2_RUN;
        default: state_next = M2_RUN;
      endcase
    end
    if (busy) begin
      control_signal_m2 = '0;
      rd_m2             = '0;
    end
  end

  assign load_word = dmem_rvalid ? dmem_rdata : hold_data;

  load_extend u_load_extend (
    .rdata    (load_word),
    .funct3   (funct3_q),
    .offset   (result_q[1:0]),
    .extended (extended)
  );

  assign memresult_m2 = ctrl_q.memread ? extended : '0;
  assign result_m2    = result_q;

  always_comb begin
    req_d.rd_m2       = rd_m2;
    req_d.regwrite_m2 = control_signal_m2.regwrite;
    req_d.result_m2   = ctrl_q.memread ? memresult_m2 : result_q;
    req_d.busy_m2     = busy;
  end

  assign hazard_bus.req = req_d;

endmodule

// File: tb/tb_stage_m2.sv
// Bench for stage_m2: extension table, multi-cycle corner sequences, random run vs model.
module tb_stage_m2;
  import riscv_defines::*;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  control_signal_t control_signal_m1, control_signal_m2;
  logic [4:0]      rd_m1, rd_m2;
  logic [2:0]      funct3_m1;
  logic [31:0]     result_m1, dmem_rdata, memresult_m2, result_m2;
  logic            dmem_rvalid;
  hazard_interface hz();

  stage_m2 dut (
    .clk               (clk),
    .reset             (reset),
    .control_signal_m1 (control_signal_m1),
    .rd_m1             (rd_m1),
    .funct3_m1         (funct3_m1),
    .result_m1         (result_m1),
    .dmem_rdata        (dmem_rdata),
    .dmem_rvalid       (dmem_rvalid),
    .control_signal_m2 (control_signal_m2),
    .rd_m2             (rd_m2),
    .memresult_m2      (memresult_m2),
    .result_m2         (result_m2),
    .hazard_bus        (hz)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: instruction sitting in M2 plus any load data parked during a stall.
  control_signal_t m_ctrl;
  logic [4:0]      m_rd;
  logic [2:0]      m_f3;
  logic [31:0]     m_addr, m_hd;
  logic            m_hv, m_accept;

  vec_t tbl [12];

  function automatic control_signal_t mk(input logic rw, input logic ld);
    control_signal_t c;
    c = '0;
    c.regwrite  = rw;
    c.memread   = ld;
    c.resultsrc = ld ? RESULT_MEM : RESULT_ALU;
    return c;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [31:0] a);
    int unsigned b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      F3_LB:   return (b >= 128) ? b - 32'd256 : b;
      F3_LBU:  return b;
      F3_LH:   return (h >= 32768) ? h - 32'd65536 : h;
      F3_LHU:  return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_rd = '0; m_f3 = '0; m_addr = '0; m_hd = '0; m_hv = 1'b0; m_accept = 1'b1;
  endtask

  task automatic check_model();
    logic busy;
    logic [31:0] word, mem;
    control_signal_t c;
    logic [4:0] r;
    busy = m_ctrl.memread && !dmem_rvalid && !m_hv;
    word = dmem_rvalid ? dmem_rdata : m_hd;
    mem  = m_ctrl.memread ? ref_load(word, m_f3, m_addr) : 32'h0;
    c    = busy ? control_signal_t'('0) : m_ctrl;
    r    = busy ? 5'd0 : m_rd;
    chk("busy", 32'(hz.req.busy_m2), 32'(busy));
    chk("ctrl", 32'(control_signal_m2), 32'(c));
    chk("rd", 32'(rd_m2), 32'(r));
    chk("result", result_m2, m_addr);
    chk("fwd_regwrite", 32'(hz.req.regwrite_m2), 32'(c.regwrite));
    chk("fwd_rd", 32'(hz.req.rd_m2), 32'(r));
    if (!busy) begin
      chk("memresult", memresult_m2, mem);
      chk("fwd_result", hz.req.result_m2, m_ctrl.memread ? mem : m_addr);
    end
  endtask

  task automatic model_tick();
    logic busy;
    busy = m_ctrl.memread && !dmem_rvalid && !m_hv;
    m_accept = 1'b0;
    if (hz.res.flush_m2) begin
      m_ctrl = '0;
      m_hv   = 1'b0;
    end else if (!hz.res.stall_m2 && !busy) begin
      m_ctrl = control_signal_m1; m_rd = rd_m1; m_f3 = funct3_m1; m_addr = result_m1;
      m_hv = 1'b0; m_accept = 1'b1;
    end else if (hz.res.stall_m2 && dmem_rvalid && m_ctrl.memread) begin
      m_hv = 1'b1;
      m_hd = dmem_rdata;
    end
  endtask

  task automatic apply(input control_signal_t c, input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] a, input logic rv, input logic [31:0] rdat,
                       input logic st, input logic fl);
    @(negedge clk);
    control_signal_m1 = c; rd_m1 = rd; funct3_m1 = f3; result_m1 = a;
    dmem_rvalid = rv; dmem_rdata = rdat;
    hz.res.stall_m2 = st; hz.res.flush_m2 = fl;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  initial begin
    control_signal_t nop, ldc, alu, rc;
    logic [4:0]  rrd;
    logic [2:0]  rf3;
    logic [31:0] ra;
    int wb;

    nop = '0; ldc = mk(1'b1, 1'b1); alu = mk(1'b1, 1'b0);
    tbl[0]  = '{F3_LB,  2'd0, 32'h8000_7F80, 32'hFFFF_FF80};
    tbl[1]  = '{F3_LB,  2'd1, 32'h8000_7F80, 32'h0000_007F};
    tbl[2]  = '{F3_LB,  2'd3, 32'h8000_7F80, 32'hFFFF_FF80};
    tbl[3]  = '{F3_LBU, 2'd0, 32'h8000_7F80, 32'h0000_0080};
    tbl[4]  = '{F3_LBU, 2'd2, 32'h8000_7F80, 32'h0000_0000};
    tbl[5]  = '{F3_LHU, 2'd2, 32'hBEEF_1234, 32'h0000_BEEF};
    tbl[6]  = '{F3_LH,  2'd2, 32'hBEEF_1234, 32'hFFFF_BEEF};
    tbl[7]  = '{F3_LH,  2'd0, 32'hBEEF_1234, 32'h0000_1234};
    tbl[8]  = '{F3_LH,  2'd3, 32'hBEEF_1234, 32'hFFFF_BEEF};
    tbl[9]  = '{F3_LW,  2'd3, 32'h1234_5678, 32'h1234_5678};
    tbl[10] = '{3'b011, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[11] = '{F3_LHU, 2'd1, 32'hBEEF_8001, 32'h0000_8001};

    reset = 1'b1;
    control_signal_m1 = '0; rd_m1 = '0; funct3_m1 = '0; result_m1 = '0;
    dmem_rdata = '0; dmem_rvalid = 1'b0; hz.res = '0;
    model_reset();
    #12;
    chk("reset_ctrl", 32'(control_signal_m2), 32'h0);
    chk("reset_busy", 32'(hz.req.busy_m2), 32'h0);
    chk("reset_memresult", memresult_m2, 32'h0);
    chk("reset_result", result_m2, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Extension table: load enters M2 with rvalid in the same cycle.
    for (int i = 0; i < 12; i++) begin
      apply(ldc, 5'(i + 1), tbl[i].f3, 32'h0000_0100 + 32'(tbl[i].off), 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      apply(nop, 5'd0, 3'd0, 32'h0, 1'b1, tbl[i].rdata, 1'b0, 1'b0);
      chk("tbl_memresult", memresult_m2, tbl[i].exp);
      chk("tbl_regwrite", 32'(hz.req.regwrite_m2), 32'h1);
      tick();
    end

    // LW with rvalid delayed three cycles.
    apply(ldc, 5'd5, F3_LW, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    wb = 0;
    for (int k = 0; k < 3; k++) begin
      apply(alu, 5'd6, 3'd0, 32'h0000_0AAA, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("lw_busy", 32'(hz.req.busy_m2), 32'h1);
      chk("lw_bubble", 32'(control_signal_m2), 32'h0);
      if (hz.req.regwrite_m2 && rd_m2 == 5'd5) wb++;
      tick();
    end
    apply(alu, 5'd6, 3'd0, 32'h0000_0AAA, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    chk("lw_data", memresult_m2, 32'hCAFE_F00D);
    chk("lw_rd", 32'(rd_m2), 32'd5);
    if (hz.req.regwrite_m2 && rd_m2 == 5'd5) wb++;
    tick();
    apply(nop, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("lw_next_result", result_m2, 32'h0000_0AAA);
    if (hz.req.regwrite_m2 && rd_m2 == 5'd5) wb++;
    chk("lw_single_wb", 32'(wb), 32'd1);
    tick();

    // rvalid during an external stall is parked and delivered on release.
    apply(ldc, 5'd7, F3_LW, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    apply(alu, 5'd8, 3'd0, 32'h0000_0BBB, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      apply(alu, 5'd8, 3'd0, 32'h0000_0BBB, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("stall_hold_valid", 32'(dut.hold_valid), 32'h1);
      chk("stall_not_busy", 32'(hz.req.busy_m2), 32'h0);
      tick();
    end
    apply(alu, 5'd8, 3'd0, 32'h0000_0BBB, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_release_data", memresult_m2, 32'h1234_5678);
    chk("stall_release_wb", 32'(hz.req.regwrite_m2), 32'h1);
    chk("stall_release_rd", 32'(rd_m2), 32'd7);
    tick();
    apply(nop, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("hold_cleared", 32'(dut.hold_valid), 32'h0);
    tick();

    // Flush together with rvalid while waiting.
    apply(ldc, 5'd9, F3_LW, 32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    apply(alu, 5'd10, 3'd0, 32'h0000_0CCC, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    apply(alu, 5'd10, 3'd0, 32'h0000_0CCC, 1'b1, 32'h5555_AAAA, 1'b0, 1'b1);
    chk("flush_in_wait", 32'(dut.state), 32'(M2_WAIT));
    tick();
    apply(alu, 5'd10, 3'd0, 32'h0000_0CCC, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("flush_ctrl", 32'(control_signal_m2), 32'h0);
    chk("flush_no_wb", 32'(hz.req.regwrite_m2), 32'h0);
    chk("flush_fsm", 32'(dut.state), 32'(M2_RUN));
    chk("flush_hold", 32'(dut.hold_valid), 32'h0);
    tick();
    apply(nop, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("flush_then_alu", 32'(rd_m2), 32'd10);
    tick();

    // Reset pulsed while waiting on a load.
    apply(ldc, 5'd11, F3_LW, 32'h500, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    apply(nop, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    apply(nop, 5'd0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_pre_wait", 32'(dut.state), 32'(M2_WAIT));
    #1 reset = 1'b1;
    #1;
    chk("rst_ctrl", 32'(control_signal_m2), 32'h0);
    chk("rst_rd", 32'(rd_m2), 32'h0);
    chk("rst_result", result_m2, 32'h0);
    chk("rst_memresult", memresult_m2, 32'h0);
    chk("rst_fwd_result", hz.req.result_m2, 32'h0);
    chk("rst_busy", 32'(hz.req.busy_m2), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_fsm", 32'(dut.state), 32'(M2_RUN));
    chk("rst_busy_after", 32'(hz.req.busy_m2), 32'h0);
    tick();

    // Random traffic against the model; M1 holds until the model accepts it.
    rc = nop; rrd = '0; rf3 = '0; ra = '0;
    for (int n = 0; n < 600; n++) begin
      if (m_accept) begin
        rc  = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rrd = 5'($urandom_range(0, 31));
        rf3 = 3'($urandom_range(0, 7));
        ra  = $urandom;
      end
      apply(rc, rrd, rf3, ra,
            $urandom_range(0, 99) < 40, $urandom,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 6);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
